line_cmd_parser: RTL and testbench

- Upstream neighbour of the control/framebuffer write path.
- Consumes received UART bytes and parses ASCII row-load commands of the form 'L' + 2 decimal row digits + 2*ROW_BYTES hex digits + line terminator.
- Drives framebuffer port-A byte writes (8-bit data, 12-bit address) into the dual-port frame memory that the fetch/scan path reads.
- Reports command completion and errors to the debug path.

---
 rtl/line_cmd_parser_pkg.sv | 26 ++
 rtl/line_cmd_parser_if.sv | 27 ++
 rtl/line_cmd_parser_ascii_hex_decode.sv | 28 ++
 rtl/line_cmd_parser.sv | 160 ++++++++++++++++
 tb/tb_line_cmd_parser.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/line_cmd_parser_pkg.sv
// Shared types and ASCII constants for the row-load command parser and the
// debugger command path.
package line_cmd_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW_HI,
        ROW_LO,
        DATA_HI,
        DATA_LO,
        EOL
    } parser_state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_CR  = 8'h0D;

    // Framebuffer address is {row, byte_idx}.
    localparam int ROW_W = 5;
    localparam int IDX_W = 7;

    function automatic logic is_term(input logic [7:0] c);
        return (c == CHAR_LF) || (c == CHAR_CR);
    endfunction

endpackage

// File: rtl/line_cmd_parser_if.sv
// Byte-stream input, framebuffer port-A write and status signals of the parser.
// The parser drives the master modport; its environment uses the slave side.
interface line_cmd_parser_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [7:0]            ram_data_out;
    logic                  ram_write_enable;
    logic                  ram_clk_enable;
    logic                  busy;
    logic                  line_done;
    logic                  line_error;

    modport master (
        input  rx_data, rx_valid,
        output ram_address, ram_data_out, ram_write_enable, ram_clk_enable,
        output busy, line_done, line_error
    );

    modport slave (
        output rx_data, rx_valid,
        input  ram_address, ram_data_out, ram_write_enable, ram_clk_enable,
        input  busy, line_done, line_error
    );
endinterface

// File: rtl/line_cmd_parser_ascii_hex_decode.sv
// Combinational ASCII digit decoder: value plus hex/decimal classification.
// Shared with the debugger command path.
module ascii_hex_decode
    import line_cmd_parser_pkg::*;
(
    input  logic [7:0] char_i,
    output logic [3:0] value_o,
    output logic       is_hex_o,
    output logic       is_dec_o
);

    // 'a'-'f' and 'A'-'F' both have low nibble 1..6, so value = nibble + 9.
    always_comb begin
        value_o  = 4'd0;
        is_hex_o = 1'b0;
        is_dec_o = 1'b0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            value_o  = char_i[3:0];
            is_hex_o = 1'b1;
            is_dec_o = 1'b1;
        end else if ((char_i >= 8'h61 && char_i <= 8'h66) ||
                     (char_i >= 8'h41 && char_i <= 8'h46)) begin
            value_o  = char_i[3:0] + 4'd9;
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/line_cmd_parser.sv
// Parses "L<rr><hex...><CR|LF>" row-load commands into framebuffer byte writes.
// Optional saturating error counter enabled by LINE_CMD_PARSER_ERRCNT_EN.
//
// state   | meaning
// IDLE    | waiting for 'L', everything else ignored
// ROW_HI  | expecting row tens digit
// ROW_LO  | expecting row units digit, range check
// DATA_HI | expecting high nibble of next byte
// DATA_LO | expecting low nibble, issues the write
// EOL     | expecting CR or LF
module line_cmd_parser
    import line_cmd_parser_pkg::*;
#(
    parameter int ROWS       = 32,
    parameter int ROW_BYTES  = 128,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk_in,
    input  logic                    reset,
    line_cmd_parser_if.master       bus
`ifdef LINE_CMD_PARSER_ERRCNT_EN
    ,
    output logic [7:0]              error_count,
    input  logic                    error_count_clear
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROW_BYTES - 1);

    parser_state_e         state_q;
    logic [3:0]            tens_q;
    logic [3:0]            hi_nib_q;
    logic [ROW_W-1:0]      row_q;
    logic [IDX_W-1:0]      byte_idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            data_q;
    logic                  we_q;
    logic                  done_q;
    logic                  err_q;

    logic [3:0] nib;
    logic       is_hex;
    logic       is_dec;
    logic [6:0] row_sum;

    ascii_hex_decode u_hex (
        .char_i   (bus.rx_data),
        .value_o  (nib),
        .is_hex_o (is_hex),
        .is_dec_o (is_dec)
    );

    // Up to 99, so 7 bits before the range check.
    assign row_sum = 7'(tens_q) * 7'd10 + 7'(nib);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tens_q     <= '0;
            hi_nib_q   <= '0;
            row_q      <= '0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.rx_valid) begin
                if (bus.rx_data == CMD_LOAD) begin
                    // 'L' always restarts; mid-line it also aborts the old line.
                    err_q   <= (state_q != IDLE);
                    state_q <= ROW_HI;
                end else begin
                    case (state_q)
                        IDLE: ;
                        ROW_HI: begin
                            if (is_dec) begin
                                tens_q  <= nib;
                                state_q <= ROW_LO;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        ROW_LO: begin
                            if (is_dec && row_sum < 7'(ROWS)) begin
                                row_q      <= row_sum[ROW_W-1:0];
                                byte_idx_q <= '0;
                                state_q    <= DATA_HI;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        DATA_HI: begin
                            if (is_hex) begin
                                hi_nib_q <= nib;
                                state_q  <= DATA_LO;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        DATA_LO: begin
                            if (is_hex) begin
                                we_q   <= 1'b1;
                                addr_q <= ADDR_WIDTH'({row_q, byte_idx_q});
                                data_q <= {hi_nib_q, nib};
                                if (byte_idx_q == IDX_LAST) begin
                                    state_q <= EOL;
                                end else begin
                                    byte_idx_q <= byte_idx_q + 1'b1;
                                    state_q    <= DATA_HI;
                                end
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        EOL: begin
                            done_q  <= is_term(bus.rx_data);
                            err_q   <= !is_term(bus.rx_data);
                            state_q <= IDLE;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.ram_address      = addr_q;
    assign bus.ram_data_out     = data_q;
    assign bus.ram_write_enable = we_q;
    assign bus.ram_clk_enable   = we_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.line_done        = done_q;
    assign bus.line_error       = err_q;

`ifdef LINE_CMD_PARSER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (error_count_clear) begin
            err_cnt_q <= '0;
        end else if (err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign error_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_line_cmd_parser.sv
// Self-checking bench for line_cmd_parser: directed line table, randomized
// lines against a position-based reference model, and mid-line reset.
module tb_line_cmd_parser;

    localparam int ROWS = 32;
    localparam int RB   = 128;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    always #5 clk_in = ~clk_in;

    line_cmd_parser_if #(.ADDR_WIDTH(12)) bus ();

`ifdef LINE_CMD_PARSER_ERRCNT_EN
    logic [7:0] error_count;
    logic       error_count_clear = 1'b0;
`endif

    line_cmd_parser #(.ROWS(ROWS), .ROW_BYTES(RB), .ADDR_WIDTH(12)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
`ifdef LINE_CMD_PARSER_ERRCNT_EN
        ,
        .error_count       (error_count),
        .error_count_clear (error_count_clear)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int wr_seen, done_seen, err_seen;

    // Reference model: position within the current line (-1 = not in a line).
    int m_pos = -1;
    int m_tens, m_row, m_hi;
    bit e_we, e_done, e_err;
    int e_addr, e_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        string hx = "0123456789abcdefABCDEF";
        for (int i = 0; i < 22; i++)
            if (b == hx[i]) return (i < 16) ? i : i - 6;
        return -1;
    endfunction

    function automatic int decval(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        return -1;
    endfunction

    task automatic model_abort();
        e_err = 1'b1;
        m_pos = -1;
    endtask

    task automatic model_step(input logic [7:0] b);
        int d, h, k;
        e_we = 0; e_done = 0; e_err = 0;
        if (b == 8'h4C) begin
            e_err = (m_pos >= 0);
            m_pos = 0;
        end else if (m_pos == 0) begin
            d = decval(b);
            if (d < 0) model_abort();
            else begin m_tens = d; m_pos = 1; end
        end else if (m_pos == 1) begin
            d = decval(b);
            if (d < 0) model_abort();
            else begin
                m_row = m_tens * 10 + d;
                if (m_row >= ROWS) model_abort();
                else m_pos = 2;
            end
        end else if (m_pos >= 2 && m_pos < 2 + 2 * RB) begin
            h = hexval(b);
            if (h < 0) model_abort();
            else begin
                k = m_pos - 2;
                if (k % 2 == 0) m_hi = h;
                else begin
                    e_we   = 1;
                    e_addr = m_row * RB + k / 2;
                    e_data = m_hi * 16 + h;
                end
                m_pos++;
            end
        end else if (m_pos == 2 + 2 * RB) begin
            if (b == 8'h0A || b == 8'h0D) e_done = 1;
            else e_err = 1;
            m_pos = -1;
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] b);
        @(negedge clk_in);
        bus.rx_valid = v;
        bus.rx_data  = b;
        if (v) model_step(b);
        else begin e_we = 0; e_done = 0; e_err = 0; end
        @(posedge clk_in);
        #1;
        check("write_enable", bus.ram_write_enable, e_we);
        check("clk_enable", bus.ram_clk_enable, e_we);
        check("line_done", bus.line_done, e_done);
        check("line_error", bus.line_error, e_err);
        check("busy", bus.busy, m_pos >= 0);
        if (e_we) begin
            check("address", bus.ram_address, e_addr);
            check("data", bus.ram_data_out, e_data);
        end
        wr_seen   += bus.ram_write_enable;
        done_seen += bus.line_done;
        err_seen  += bus.line_error;
    endtask

    task automatic send_str(input string s, input int gap_max);
        for (int i = 0; i < s.len(); i++) begin
            repeat ($urandom_range(0, gap_max)) cyc(1'b0, 8'($urandom));
            cyc(1'b1, s[i]);
        end
    endtask

    typedef struct {
        string name;
        string stim;
        int    n_wr;
        int    n_done;
        int    n_err;
    } vec_t;

    vec_t  vecs[$];
    string a5, asc, junk, s;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        a5 = ""; asc = "";
        for (int k = 0; k < RB; k++) begin
            a5  = {a5, "A5"};
            asc = {asc, (k % 2) ? $sformatf("%02X", k) : $sformatf("%02x", k)};
        end

        vecs.push_back('{"full_row5",    {"L05", a5, "\n"},            128, 1, 0});
        vecs.push_back('{"row31_ascend", {"L31", asc, "\r"},           128, 1, 0});
        vecs.push_back('{"row_range",    "L32",                        0,   0, 1});
        vecs.push_back('{"bad_char",     "L0012Gxyz\n",                1,   0, 1});
        vecs.push_back('{"resync",       {"L01AB", "L02", a5, "\n"},   129, 1, 1});
        vecs.push_back('{"crlf_pair",    {"L00", asc, "\r\n"},         128, 1, 0});
        vecs.push_back('{"bad_eol",      {"L07", a5, "Z"},             128, 0, 1});
        vecs.push_back('{"row_lo_term",  "L3\r",                       0,   0, 1});
        vecs.push_back('{"junk_then_lf", "Qq\n\rL19fF\n",              1,   0, 1});
        vecs.push_back('{"row_99",       "L99",                        0,   0, 1});
        vecs.push_back('{"row_hexdigit", "L3A",                        0,   0, 1});

        #1;
        check("reset_we", bus.ram_write_enable, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_addr", bus.ram_address, 0);
        check("reset_strobes", {bus.line_done, bus.line_error, bus.ram_clk_enable}, 0);
        @(negedge clk_in);
        reset = 1'b1;
        cyc(1'b0, 8'h00);

        foreach (vecs[i]) begin
            wr_seen = 0; done_seen = 0; err_seen = 0;
            send_str(vecs[i].stim, (i % 2) ? 2 : 0);
            cyc(1'b0, 8'h00);
            cyc(1'b0, 8'h00);
            check({vecs[i].name, "_writes"}, wr_seen, vecs[i].n_wr);
            check({vecs[i].name, "_done"}, done_seen, vecs[i].n_done);
            check({vecs[i].name, "_errors"}, err_seen, vecs[i].n_err);
            check({vecs[i].name, "_idle"}, bus.busy, 0);
        end

        // Randomized lines, sometimes truncated or corrupted.
        junk = "GzL\n!:";
        for (int n = 0; n < 25; n++) begin
            int nd, t;
            s  = {"L", $sformatf("%02d", $urandom_range(0, 36))};
            nd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 2 * RB;
            for (int j = 0; j < nd; j++) s = {s, $sformatf("%1h", $urandom_range(0, 15))};
            t = $urandom_range(0, 3);
            s = {s, (t == 0) ? "\n" : (t == 1) ? "\r" : (t == 2) ? "\r\n" : "Z"};
            if ($urandom_range(0, 5) == 0)
                s.putc($urandom_range(1, s.len() - 1), junk[$urandom_range(0, 5)]);
            send_str(s, $urandom_range(0, 2));
        end
        send_str("\n\n", 0);

        // Reset asserted while a low nibble is being presented.
        send_str("L031", 0);
        @(negedge clk_in);
        bus.rx_valid = 1'b1;
        bus.rx_data  = "2";
        #2 reset = 1'b0;
        #1;
        check("midreset_outputs",
              {bus.ram_write_enable, bus.ram_clk_enable, bus.busy, bus.line_done,
               bus.line_error, bus.ram_address, bus.ram_data_out}, 0);
        @(posedge clk_in);
        #1;
        check("midreset_no_write", bus.ram_write_enable, 0);
        @(negedge clk_in);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        m_pos = -1;
        cyc(1'b0, 8'h00);
        check("after_reset_busy", bus.busy, 0);

`ifdef LINE_CMD_PARSER_ERRCNT_EN
        check("errcnt_reset", error_count, 0);
        send_str("L32L32L32", 0);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        check("errcnt_three", error_count, 3);
        error_count_clear = 1'b1;
        cyc(1'b0, 8'h00);
        error_count_clear = 1'b0;
        check("errcnt_clear", error_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
